// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sad_pkg
//  Description : Shared defaults and control-strobe bundle for the SAD datapath.
//  Revision    : 1.0
// ============================================================================
package sad_pkg;

    localparam int c_DEF_DATA_W     = 32;
    localparam int c_DEF_ADDR_W     = 9;
    localparam int c_DEF_BLOCK_SIZE = 256;

    // One bundle per cycle of controller strobes, grouped per register.
    typedef struct packed {
        logic idx_inc;
        logic idx_clr;
        logic sum_ld;
        logic sum_clr;
        logic sad_ld;
        logic sad_clr;
    } sad_ctrl_t;

endpackage : sad_pkg
`default_nettype wire

// File: rtl/abs_diff.sv
`default_nettype none
// ============================================================================
//  Module      : abs_diff
//  Description : Combinational unsigned absolute difference |a - b|.
//  Revision    : 1.0
// ============================================================================
module abs_diff #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_diff
);

    logic w_a_ge_b;

    assign w_a_ge_b = (i_a >= i_b);
    assign o_diff   = w_a_ge_b ? (i_a - i_b) : (i_b - i_a);

endmodule : abs_diff
`default_nettype wire

// File: rtl/custom_sad.sv
`default_nettype none
// ============================================================================
//  Module      : custom_sad
//  Description : SAD datapath: saturating index counter, running |A-B| sum and
//                result register, steered by an external controller.
//  Revision    : 1.0
// ============================================================================
module custom_sad
    import sad_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int BLOCK_SIZE = c_DEF_BLOCK_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic              i_inc,
    input  logic              i_clr,
    input  logic              sum_ld,
    input  logic              sum_clr,
    input  logic              sadreg_ld,
    input  logic              sadreg_clr,
    output logic [DATA_W-1:0] sad,
    output logic [ADDR_W-1:0] ab_addr,
    output logic              i_ld_256
);

    localparam logic [ADDR_W-1:0] c_BLOCK_END = ADDR_W'(BLOCK_SIZE);
    localparam logic [ADDR_W-1:0] c_IDX_ONE   = ADDR_W'(1);

    sad_ctrl_t         w_ctrl;
    logic [DATA_W-1:0] w_absdiff;
    logic              w_in_block;

    logic [ADDR_W-1:0] r_idx_q, w_idx_d;
    logic [DATA_W-1:0] r_sum_q, w_sum_d;
    logic [DATA_W-1:0] r_sad_q, w_sad_d;

    assign w_ctrl = '{
        idx_inc: i_inc,
        idx_clr: i_clr,
        sum_ld:  sum_ld,
        sum_clr: sum_clr,
        sad_ld:  sadreg_ld,
        sad_clr: sadreg_clr
    };

    abs_diff #(
        .DATA_W (DATA_W)
    ) u_abs_diff (
        .i_a    (a_data),
        .i_b    (b_data),
        .o_diff (w_absdiff)
    );

    assign w_in_block = (r_idx_q < c_BLOCK_END);

    // Counter saturates at the block end so the controller can over-strobe safely.
    always_comb begin
        w_idx_d = r_idx_q;
        if (w_ctrl.idx_clr) begin
            w_idx_d = '0;
        end else if (w_ctrl.idx_inc && w_in_block) begin
            w_idx_d = r_idx_q + c_IDX_ONE;
        end
    end

    always_comb begin
        w_sum_d = r_sum_q;
        if (w_ctrl.sum_clr) begin
            w_sum_d = '0;
        end else if (w_ctrl.sum_ld) begin
            w_sum_d = r_sum_q + w_absdiff;
        end
    end

    // Loads the pre-edge sum, so a simultaneous sum_ld is published one cycle later.
    always_comb begin
        w_sad_d = r_sad_q;
        if (w_ctrl.sad_clr) begin
            w_sad_d = '0;
        end else if (w_ctrl.sad_ld) begin
            w_sad_d = r_sum_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx_q <= '0;
            r_sum_q <= '0;
            r_sad_q <= '0;
        end else begin
            r_idx_q <= w_idx_d;
            r_sum_q <= w_sum_d;
            r_sad_q <= w_sad_d;
        end
    end

    assign sad      = r_sad_q;
    assign ab_addr  = r_idx_q;
    assign i_ld_256 = w_in_block;

endmodule : custom_sad
`default_nettype wire

// File: tb/tb_custom_sad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_custom_sad
//  Description : Scoreboard bench for custom_sad with directed vectors.
//  Revision    : 1.0
// ============================================================================
module tb_custom_sad;

    localparam int c_DW = 32;
    localparam int c_AW = 9;

    logic            clk;
    logic            rst;
    logic [c_DW-1:0] a_data;
    logic [c_DW-1:0] b_data;
    logic            i_inc;
    logic            i_clr;
    logic            sum_ld;
    logic            sum_clr;
    logic            sadreg_ld;
    logic            sadreg_clr;
    logic [c_DW-1:0] sad;
    logic [c_AW-1:0] ab_addr;
    logic            i_ld_256;

    typedef struct {
        string           name;
        logic [c_DW-1:0] sad;
        logic [c_AW-1:0] addr;
        logic            flag;
    } exp_t;

    exp_t r_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    custom_sad #(
        .DATA_W     (c_DW),
        .ADDR_W     (c_AW),
        .BLOCK_SIZE (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_data     (a_data),
        .b_data     (b_data),
        .i_inc      (i_inc),
        .i_clr      (i_clr),
        .sum_ld     (sum_ld),
        .sum_clr    (sum_clr),
        .sadreg_ld  (sadreg_ld),
        .sadreg_clr (sadreg_clr),
        .sad        (sad),
        .ab_addr    (ab_addr),
        .i_ld_256   (i_ld_256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs move only on posedge, so compare at negedge.
    always @(negedge clk) begin
        if (r_q.size() > 0) begin
            exp_t e;
            e = r_q.pop_front();
            n_checks++;
            if (sad !== e.sad || ab_addr !== e.addr || i_ld_256 !== e.flag) begin
                n_fail++;
                $display("FAIL %s: got sad=%0h addr=%0d flag=%0b, expected sad=%0h addr=%0d flag=%0b",
                         e.name, sad, ab_addr, i_ld_256, e.sad, e.addr, e.flag);
            end
        end
    end

    // ctl = {rst, i_inc, i_clr, sum_ld, sum_clr, sadreg_ld, sadreg_clr}
    task automatic step(input logic [6:0] ctl, input logic [c_DW-1:0] a, input logic [c_DW-1:0] b,
                        input bit chk, input logic [c_DW-1:0] esad, input logic [c_AW-1:0] eaddr,
                        input logic eflag, input string nm);
        exp_t e;
        @(negedge clk);
        {rst, i_inc, i_clr, sum_ld, sum_clr, sadreg_ld, sadreg_clr} = ctl;
        a_data = a;
        b_data = b;
        @(posedge clk);
        #1;
        if (chk) begin
            e.name = nm;
            e.sad  = esad;
            e.addr = eaddr;
            e.flag = eflag;
            r_q.push_back(e);
        end
    endtask

    localparam logic [6:0] c_RST  = 7'b1000000;
    localparam logic [6:0] c_INC  = 7'b0100000;
    localparam logic [6:0] c_ICLR = 7'b0010000;
    localparam logic [6:0] c_SLD  = 7'b0001000;
    localparam logic [6:0] c_SCLR = 7'b0000100;
    localparam logic [6:0] c_RLD  = 7'b0000010;
    localparam logic [6:0] c_RCLR = 7'b0000001;
    localparam logic [6:0] c_CLRA = c_ICLR | c_SCLR | c_RCLR;

    initial begin
        int k;
        {rst, i_inc, i_clr, sum_ld, sum_clr, sadreg_ld, sadreg_clr} = '0;
        a_data = '0;
        b_data = '0;

        // Reset with random controls
        for (int r = 0; r < 2; r++)
            step(c_RST | 7'($urandom_range(0, 63)), $urandom, $urandom, 1, 0, 0, 1, "reset");

        // Accumulate with sadreg lag
        step(c_CLRA, 0, 0, 1, 0, 0, 1, "clear_all_1");
        step(c_CLRA, 0, 0, 1, 0, 0, 1, "clear_all_2");
        step(c_INC | c_SLD | c_RLD, 50, 100, 1, 0,   1, 1, "lag_edge1");
        step(c_INC | c_SLD | c_RLD, 50, 100, 1, 50,  2, 1, "lag_edge2");
        step(c_INC | c_SLD | c_RLD, 50, 100, 1, 100, 3, 1, "lag_edge3");

        // Symmetry and zero difference
        step(c_CLRA, 0, 0, 1, 0, 0, 1, "sym_clear");
        step(c_SLD, 100, 50, 1, 0, 0, 1, "sym_a_gt_b");
        step(c_SLD | c_RLD, 7, 7, 1, 50, 0, 1, "sym_publish");
        step(c_RLD, 0, 0, 1, 50, 0, 1, "sym_equal_no_change");

        // Full block: A[i]=i, B[i]=255-i
        step(c_CLRA, 0, 0, 1, 0, 0, 1, "blk_clear");
        k = 0;
        while (k < 300) begin
            step(c_INC | c_SLD, c_DW'(k), c_DW'(255 - k), (k % 64 == 0) || k >= 254,
                 0, c_AW'(k + 1), (k + 1) < 256, "blk_loop");
            k++;
            if (i_ld_256 !== 1'b1) break;
        end
        n_checks++;
        if (k != 256) begin
            n_fail++;
            $display("FAIL blk_iterations: got %0d, expected 256", k);
        end
        step(c_RLD, 0, 0, 1, 32768, 256, 0, "blk_sad");
        step(c_INC, 0, 0, 1, 32768, 256, 0, "blk_saturate");
        step(c_INC, 0, 0, 1, 32768, 256, 0, "blk_saturate2");

        // Priority: clear beats load
        step(c_CLRA, 0, 0, 1, 0, 0, 1, "pri_clear");
        step(c_SLD, 9, 2, 1, 0, 0, 1, "pri_sum7");
        step(c_SLD | c_SCLR | c_RLD, 9, 2, 1, 7, 0, 1, "pri_sumclr_wins");
        step(c_RLD, 0, 0, 1, 0, 0, 1, "pri_sum_is_zero");
        step(c_SLD, 5, 0, 1, 0, 0, 1, "pri_sum5");
        step(c_RLD | c_RCLR, 0, 0, 1, 0, 0, 1, "pri_sadclr_wins");
        step(c_RLD, 0, 0, 1, 5, 0, 1, "pri_sad5");
        step(c_INC, 0, 0, 1, 5, 1, 1, "pri_inc1");
        step(c_INC, 0, 0, 1, 5, 2, 1, "pri_inc2");
        step(c_INC | c_ICLR, 0, 0, 1, 5, 0, 1, "pri_iclr_wins");

        // Modulo wrap of the sum
        step(c_CLRA, 0, 0, 1, 0, 0, 1, "wrap_clear");
        step(c_SLD, 32'hFFFF_FFF0, 0, 1, 0, 0, 1, "wrap_load");
        step(c_SLD | c_RLD, 0, 32'h20, 1, 32'hFFFF_FFF0, 0, 1, "wrap_pre");
        step(c_RLD, 0, 0, 1, 32'h10, 0, 1, "wrap_result");

        // Mid-run reset at i=100
        step(c_CLRA, 0, 0, 1, 0, 0, 1, "mid_clear");
        for (int j = 0; j < 100; j++)
            step(c_INC | c_SLD, 3, 1, j == 99, 0, 100, 1, "mid_run");
        step(c_RLD, 0, 0, 1, 200, 100, 1, "mid_sad200");
        step(c_RST | c_INC | c_SLD | c_RLD, 3, 1, 1, 0, 0, 1, "mid_reset");
        step(c_INC | c_SLD | c_RLD, 10, 4, 1, 0,  1, 1, "restart_edge1");
        step(c_INC | c_SLD | c_RLD, 10, 4, 1, 6,  2, 1, "restart_edge2");
        step(c_RLD, 0, 0, 1, 12, 2, 1, "restart_sad12");

        // Drain the scoreboard
        for (int w = 0; w < 10 && r_q.size() > 0; w++) @(negedge clk);
        @(posedge clk);
        if (r_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", r_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_custom_sad
`default_nettype wire

// File: doc/custom_sad.md
Name: custom_sad

Overview:
- Datapath of a sum-of-absolute-differences (SAD) engine. It compares two 256-element memory blocks A and B.
- An index counter addresses both memories. Each cycle an external controller FSM strobes the control inputs.
- A running sum accumulates |A[i]-B[i]|. A result register captures the final SAD.
- The block holds no FSM of its own. It only reports the loop-status flag i_ld_256 (i < 256) back to the controller.

Parameters:
- DATA_W, 32, width of a_data, b_data, the sum register and sad.
- ADDR_W, 9, width of the index counter and ab_addr.
- BLOCK_SIZE, 256, number of elements per block; the compare bound for i_ld_256.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a_data  input  DATA_W  element A[i], unsigned, read combinationally from memory at ab_addr.
- b_data  input  DATA_W  element B[i], unsigned.
- i_inc  input  1  increment the index counter.
- i_clr  input  1  clear the index counter to 0.
- sum_ld  input  1  sum <= sum + |a_data - b_data|.
- sum_clr  input  1  clear sum to 0.
- sadreg_ld  input  1  sadreg <= sum.
- sadreg_clr  input  1  clear sadreg to 0.
- sad  output  DATA_W  contents of sadreg.
- ab_addr  output  ADDR_W  current index i, driven to both memories.
- i_ld_256  output  1  status flag, high when i < BLOCK_SIZE.

Behaviour:
- Registers are i (ADDR_W), sum (DATA_W) and sadreg (DATA_W). All update on the rising clk edge.
- Reset: when rst=1, i=0, sum=0 and sadreg=0 on the next edge. Resulting outputs are sad=0, ab_addr=0, i_ld_256=1.
- Reset overrides all controls, including mid-accumulation.
- Index counter, per edge, in priority order:
  - rst.
  - i_clr gives i=0.
  - i_inc with i < BLOCK_SIZE gives i=i+1.
  - i_inc with i == BLOCK_SIZE: i holds (saturates, never wraps).
  - Otherwise i holds.
- Sum register, per edge, in priority order:
  - rst.
  - sum_clr gives 0.
  - sum_ld gives sum + absdiff.
  - Otherwise sum holds.
- absdiff = (a_data >= b_data) ? a_data - b_data : b_data - a_data. Operands are unsigned.
- The addition is modulo 2^DATA_W and wraps silently; there is no overflow flag.
- SAD register, per edge, in priority order:
  - rst.
  - sadreg_clr gives 0.
  - sadreg_ld gives sadreg = sum, using the pre-edge value of sum.
  - Otherwise sadreg holds.
- Simultaneous sum_ld and sadreg_ld: sadreg captures the old sum, so it lags sum by one cycle.
- Clear takes priority over load on the same register when both are asserted in one cycle.
- Outputs are purely combinational from registers: sad = sadreg, ab_addr = i, i_ld_256 = (i < BLOCK_SIZE). Each changes only after a clock edge.
- Latency: absdiff is combinational. One sum_ld edge adds the current pair, and the following sadreg_ld edge publishes it.
- a_data and b_data are sampled only on edges where sum_ld=1.

Decomposition:
- Shared package sad_pkg holds DATA_W, ADDR_W and BLOCK_SIZE defaults.
- One combinational sub-module abs_diff (DATA_W-parametric unsigned |a-b|), instantiated once.
- Counter, sum and sadreg stay inline in custom_sad.

Test Plan:
- Reset: rst=1 for 2 cycles with random controls -> sad=0, ab_addr=0, i_ld_256=1.
- Accumulate with lag:
  - Clear all for 2 cycles, then a=50, b=100 with i_inc, sum_ld and sadreg_ld held at 1.
  - Edge 1 -> ab_addr=1, sum=50, sad=0.
  - Edge 2 -> ab_addr=2, sad=50.
  - Edge 3 -> sad=100.
- Symmetry: a=100, b=50, then a=b=7, one sum_ld each after a clear -> sum=50, then unchanged at 50.
- Full block:
  - A[i]=i, B[i]=255-i; run the controller loop while i_ld_256=1, then load sadreg.
  - Expected sad = sum over i of |2i-255| = 32768.
  - i_ld_256 drops exactly when ab_addr=256. Extra i_inc keeps ab_addr=256.
- Priority and wrap:
  - sum_clr with sum_ld -> sum=0.
  - i_clr with i_inc -> i=0.
  - sum=0xFFFFFFF0 plus diff 0x20 -> sum=0x10.
- Mid-run reset: assert rst at i=100 -> all registers 0 next edge, then accumulation restarts correctly.
